// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, divider state encoding and
// the most-negative operand constant used for overflow detection.
package alu_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [DEF_WIDTH-1:0] MOST_NEG = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, try to
// subtract the divisor, keep the difference only when it does not go negative.
module div_step
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The incoming remainder is always below the divisor, so its MSB is zero
    // and dropping it in the shift loses nothing.
    logic unused_rem_msb;
    assign unused_rem_msb = rem[WIDTH];

    always_comb begin
        shifted  = {rem[WIDTH-1:0], dividend_bit};
        trial    = shifted - {1'b0, divisor_mag};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial : shifted;
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider (truncating toward zero) with a start/busy/done
// handshake; one restoring step per clock, fixed WIDTH+1 edge latency.
module seq_divider
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL =
        (WIDTH == DEF_WIDTH) ? WIDTH'(MOST_NEG) : {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     rem_q;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   dvs_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               sign_a_q;
    logic               sign_b_q;

    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;
    logic [WIDTH:0]     rem_next_c;
    logic               q_bit_c;
    logic [WIDTH-1:0]   q_fix_c;
    logic [WIDTH-1:0]   r_fix_c;
    logic               is_zero_c;
    logic               is_ovf_c;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem          (rem_q),
        .dividend_bit (dvd_q[WIDTH-1]),
        .divisor_mag  (dvs_q),
        .rem_next     (rem_next_c),
        .q_bit        (q_bit_c)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand magnitudes and sign-corrected results; |MIN| fits unsigned
    always_comb begin
        a_mag_c   = a[WIDTH-1] ? -a : a;
        b_mag_c   = b[WIDTH-1] ? -b : b;
        q_fix_c   = (sign_a_q ^ sign_b_q) ? -dvd_q : dvd_q;
        r_fix_c   = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        is_zero_c = (b_q == '0);
        is_ovf_c  = (a_q == MIN_VAL) && (b_q == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q         <= a;
                        b_q         <= b;
                        sign_a_q    <= a[WIDTH-1];
                        sign_b_q    <= b[WIDTH-1];
                        dvd_q       <= a_mag_c;
                        dvs_q       <= b_mag_c;
                        rem_q       <= '0;
                        cnt_q       <= CNT_W'(WIDTH - 1);
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                S_CALC: begin
                    // Quotient bits shift into the vacated dividend LSBs
                    rem_q <= rem_next_c;
                    dvd_q <= {dvd_q[WIDTH-2:0], q_bit_c};
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (is_zero_c) begin
                        q           <= '1;
                        r           <= a_q;
                        div_by_zero <= 1'b1;
                    end else if (is_ovf_c) begin
                        q        <= MIN_VAL;
                        r        <= '0;
                        overflow <= 1'b1;
                    end else begin
                        q <= q_fix_c;
                        r <= r_fix_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed corner cases plus random operands checked
// against an arithmetic model of C-style signed division.
module tb_seq_divider;

    localparam int unsigned W = 8;
    localparam int          LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_by_zero;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: C truncating division with the documented special cases
    function automatic void model(input int ia, input int ib,
                                  output int eq, output int er,
                                  output bit edz, output bit eovf);
        edz  = 1'b0;
        eovf = 1'b0;
        if (ib == 0) begin
            eq  = -1;
            er  = ia;
            edz = 1'b1;
        end else if (ia == -(1 << (W - 1)) && ib == -1) begin
            eq   = -(1 << (W - 1));
            er   = 0;
            eovf = 1'b1;
        end else begin
            eq = ia / ib;
            er = ia % ib;
        end
    endfunction

    // Drive a start for one edge, then scramble the operand inputs
    task automatic launch(input int ia, input int ib);
        start = 1'b1;
        a     = W'(ia);
        b     = W'(ib);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    // Called #1 after the accepted start edge; waits for done and checks it
    task automatic finish_op(input int ia, input int ib, input string tag);
        int           lat;
        int           eq;
        int           er;
        bit           edz;
        bit           eovf;
        logic [W-1:0] eq8;
        logic [W-1:0] er8;
        lat = 0;
        chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, " done_after_start"}, 32'(done), 32'd0);
        for (int k = 1; k <= 3 * LAT; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (k < LAT) chk({tag, " busy_mid"}, 32'(busy), 32'd1);
        end
        chk({tag, " latency"}, 32'(lat), 32'(LAT));
        model(ia, ib, eq, er, edz, eovf);
        eq8 = W'(eq);
        er8 = W'(er);
        chk({tag, " q"}, 32'(q), 32'(eq8));
        chk({tag, " r"}, 32'(r), 32'(er8));
        chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
        chk({tag, " overflow"}, 32'(overflow), 32'(eovf));
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic signed [W-1:0] ra;
        logic signed [W-1:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #2;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset q", 32'(q), 32'd0);
        chk("reset r", 32'(r), 32'd0);
        chk("reset flags", {30'd0, div_by_zero, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        launch(100, 7);    finish_op(100, 7, "p_p");
        chk("p_p q const", 32'(q), 32'd14);
        chk("p_p r const", 32'(r), 32'd2);
        launch(-100, 7);   finish_op(-100, 7, "n_p");
        launch(100, -7);   finish_op(100, -7, "p_n");
        launch(-100, -7);  finish_op(-100, -7, "n_n");
        launch(7, 0);      finish_op(7, 0, "div0");
        chk("div0 q const", 32'(q), 32'hFF);
        launch(-128, -1);  finish_op(-128, -1, "ovf");
        chk("ovf q const", 32'(q), 32'h80);
        launch(-128, 1);   finish_op(-128, 1, "min_by_one");

        // start held high: second op accepted on the done cycle
        start = 1'b1;
        a     = W'(50);
        b     = W'(5);
        @(posedge clk);
        #1;
        finish_op(50, 5, "hs1");
        @(posedge clk);
        #1;
        chk("hs back_to_back busy", 32'(busy), 32'd1);
        chk("hs back_to_back done", 32'(done), 32'd0);
        chk("hs previous q held", 32'(q), 32'd10);
        chk("hs previous r held", 32'(r), 32'd0);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        finish_op(50, 5, "hs2");

        // Reset in the middle of an operation
        launch(100, 7);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst q", 32'(q), 32'd0);
        chk("midrst r", 32'(r), 32'd0);
        chk("midrst flags", {30'd0, div_by_zero, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(posedge clk);
            #1;
            chk("midrst no_done", {30'd0, busy, done}, 32'd0);
        end
        launch(9, 4);      finish_op(9, 4, "after_rst");

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = (i % 8 == 0) ? '0 : W'($urandom);
            launch(int'(ra), int'(rb));
            finish_op(int'(ra), int'(rb), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
